esm_issue_scheduler: RTL

Issue scheduler for the ESM instruction buffer. It allocates buffer slots to incoming instructions and drives the slot index to the instruction-register table. It captures the dependency row returned for that slot, then issues ready instructions to one execution port through a valid/ready handshake. Slots free in order as completions arrive, and each completion clears its column from every pending dependency row.

---
 rtl/esm_issue_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/esm_issue_scheduler.sv
// Issue scheduler for the ESM instruction buffer: slot allocation, dependency tracking, in-order retire.
// Define ESM_SCHED_INORDER_EN for strict in-order issue; otherwise oldest-ready out-of-order issue.
module esm_issue_scheduler #(
  parameter int bs = 16,
  parameter int IW = 32,
  localparam int SW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic          in_null,
  output logic [SW-1:0] alloc_index,
  input  logic [bs-1:0] idt,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [SW-1:0] iss_index,
  output logic [IW-1:0] iss_instr,
  input  logic          cmp_valid,
  input  logic [SW-1:0] cmp_index,
  output logic [SW:0]   count,
  output logic          err
);

  localparam logic [bs-1:0] ONE_HOT0 = {{(bs-1){1'b0}}, 1'b1};

  logic [bs-1:0] vld_r, iss_r, done_r;
  logic [bs-1:0] dep_r [bs];
  logic [IW-1:0] instr_r [bs];
  logic [SW-1:0] head_r, tail_r;
  logic [SW:0]   count_r;
  logic          in_ready_r, iss_valid_r, err_r;
  logic [SW-1:0] iss_index_r;
  logic [IW-1:0] iss_instr_r;

  logic          alloc_s, retire_s, load_s, cmp_legal_s, sel_found_s;
  logic [SW-1:0] sel_idx_s, scan_idx_s;
  logic [bs-1:0] ready_s, live_s, cmp_mask_s, tail_mask_s, new_dep_s;
  logic [SW:0]   count_next_s;
`ifdef ESM_SCHED_INORDER_EN
  logic          cand_seen_s;
`endif

  // Handshakes, completion legality and the dependency row captured for the incoming instruction
  always_comb begin
    alloc_s      = in_valid && in_ready_r;
    retire_s     = vld_r[head_r] && done_r[head_r];
    load_s       = !iss_valid_r || iss_ready;
    cmp_legal_s  = cmp_valid && vld_r[cmp_index] && iss_r[cmp_index] && !done_r[cmp_index];
    cmp_mask_s   = cmp_legal_s ? (ONE_HOT0 << cmp_index) : {bs{1'b0}};
    tail_mask_s  = ONE_HOT0 << tail_r;
    live_s       = vld_r & ~done_r;
    new_dep_s    = idt & live_s & ~tail_mask_s & ~cmp_mask_s;
    count_next_s = count_r + (SW+1)'(alloc_s) - (SW+1)'(retire_s);
  end

  // Per-slot readiness: valid, not yet issued, not done, no outstanding producers
  always_comb begin
    ready_s = {bs{1'b0}};
    for (int i = 0; i < bs; i++) begin
      ready_s[i] = vld_r[i] && !iss_r[i] && !done_r[i] && (dep_r[i] == {bs{1'b0}});
    end
  end

  // Oldest-first scan starting at head, wrapping modulo bs
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {SW{1'b0}};
    scan_idx_s  = {SW{1'b0}};
`ifdef ESM_SCHED_INORDER_EN
    cand_seen_s = 1'b0;
`endif
    for (int i = 0; i < bs; i++) begin
      scan_idx_s = head_r + SW'(i);
`ifdef ESM_SCHED_INORDER_EN
      // Only the oldest unissued slot may go; if it is blocked, issue stalls
      sel_idx_s   = (!cand_seen_s && vld_r[scan_idx_s] && !iss_r[scan_idx_s]) ? scan_idx_s : sel_idx_s;
      sel_found_s = (!cand_seen_s && vld_r[scan_idx_s] && !iss_r[scan_idx_s]) ? ready_s[scan_idx_s] : sel_found_s;
      cand_seen_s = cand_seen_s || (vld_r[scan_idx_s] && !iss_r[scan_idx_s]);
`else
      sel_idx_s   = (!sel_found_s && ready_s[scan_idx_s]) ? scan_idx_s : sel_idx_s;
      sel_found_s = sel_found_s || ready_s[scan_idx_s];
`endif
    end
  end

  // Slot table: issue marking, completion with column clear, head retire, tail allocate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r  <= {bs{1'b0}};
      iss_r  <= {bs{1'b0}};
      done_r <= {bs{1'b0}};
      for (int i = 0; i < bs; i++) begin
        dep_r[i]   <= {bs{1'b0}};
        instr_r[i] <= {IW{1'b0}};
      end
    end else begin
      if (load_s && sel_found_s) begin
        iss_r[sel_idx_s] <= 1'b1;
      end
      if (cmp_legal_s) begin
        done_r[cmp_index] <= 1'b1;
        for (int i = 0; i < bs; i++) begin
          dep_r[i][cmp_index] <= 1'b0;
        end
      end
      if (retire_s) begin
        vld_r[head_r]  <= 1'b0;
        iss_r[head_r]  <= 1'b0;
        done_r[head_r] <= 1'b0;
        dep_r[head_r]  <= {bs{1'b0}};
      end
      // A null instruction is born already issued and done so it only waits to retire
      if (alloc_s) begin
        vld_r[tail_r]   <= 1'b1;
        iss_r[tail_r]   <= in_null;
        done_r[tail_r]  <= in_null;
        dep_r[tail_r]   <= new_dep_s;
        instr_r[tail_r] <= in_instr;
      end
    end
  end

  // Head/tail pointers, occupancy and the registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r     <= {SW{1'b0}};
      tail_r     <= {SW{1'b0}};
      count_r    <= {(SW+1){1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      head_r     <= head_r + SW'(retire_s);
      tail_r     <= tail_r + SW'(alloc_s);
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != (SW+1)'(bs));
    end
  end

  // Issue register: reloads when empty or being accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_r <= 1'b0;
      iss_index_r <= {SW{1'b0}};
      iss_instr_r <= {IW{1'b0}};
    end else if (load_s) begin
      iss_valid_r <= sel_found_s;
      if (sel_found_s) begin
        iss_index_r <= sel_idx_s;
        iss_instr_r <= instr_r[sel_idx_s];
      end
    end
  end

  // Sticky error on completion of a slot that is not issued-and-pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (cmp_valid && !cmp_legal_s) begin
      err_r <= 1'b1;
    end
  end

  assign in_ready    = in_ready_r;
  assign alloc_index = tail_r;
  assign iss_valid   = iss_valid_r;
  assign iss_index   = iss_index_r;
  assign iss_instr   = iss_instr_r;
  assign count       = count_r;
  assign err         = err_r;

endmodule
